// File: rtl/spi_slave_stream_if.sv
// ---------------------------------------------------------------------------
// spi_slave_stream_if
// Parallel-side stream interface of the SPI slave.
//   tx_data_bi / tx_valid_i / tx_ready_o : word to return to the SPI master,
//                                          accepted when valid && ready
//   rx_data_bo / rx_valid_o              : last complete word from the master,
//                                          rx_valid_o is a one-cycle strobe
// Modports: slave (the SPI block), master (the system side feeding it).
// ---------------------------------------------------------------------------
interface spi_slave_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data_bi;
  logic                  tx_valid_i;
  logic                  tx_ready_o;
  logic [DATA_WIDTH-1:0] rx_data_bo;
  logic                  rx_valid_o;

  modport slave (
    input  tx_data_bi, tx_valid_i,
    output tx_ready_o, rx_data_bo, rx_valid_o
  );

  modport master (
    output tx_data_bi, tx_valid_i,
    input  tx_ready_o, rx_data_bo, rx_valid_o
  );
endinterface

// File: rtl/spi_slave_stream.sv
// ---------------------------------------------------------------------------
// spi_slave_stream
// SPI slave with a one-deep TX buffer and a strobed RX word output.
// Ports:
//   clk_i, rst_i        system clock, synchronous active-high reset
//   bus (slave)         tx_data_bi/tx_valid_i/tx_ready_o, rx_data_bo/rx_valid_o
//   busy_o              chip select asserted (registered)
//   underrun_o          one-cycle strobe: a word started with the TX buffer empty
//   spi_miso_o          serial out, forced 0 while CS is high
//   spi_mosi_i, spi_sclk_i, spi_cs_i (active low)
// Parameters: DATA_WIDTH (4..32), CPOL, CPHA, MSB_FIRST.
// Optional build macro SPI_SLAVE_INPUT_SYNC_EN: two-flop synchronisers on the
// SPI inputs (adds 2 clk_i of latency); undefined, inputs are used directly.
// clk_i must run at least 4x the SCLK frequency.
// ---------------------------------------------------------------------------
module spi_slave_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  parameter int MSB_FIRST  = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  spi_slave_stream_if.slave   bus,
  output logic                busy_o,
  output logic                underrun_o,
  output logic                spi_miso_o,
  input  logic                spi_mosi_i,
  input  logic                spi_sclk_i,
  input  logic                spi_cs_i
);
  localparam int   CNT_W    = $clog2(DATA_WIDTH);
  localparam logic IDLE_LVL = (CPOL != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2} state_t;

  // Next outgoing bit of a TX word.
  function automatic logic tx_head(input logic [DATA_WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_WIDTH-1] : w[0];
  endfunction

  // TX word with the outgoing bit removed.
  function automatic logic [DATA_WIDTH-1:0] tx_next(input logic [DATA_WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
  endfunction

  // RX word with a freshly sampled bit inserted.
  function automatic logic [DATA_WIDTH-1:0] rx_insert(input logic [DATA_WIDTH-1:0] w,
                                                      input logic b);
    return (MSB_FIRST != 0) ? {w[DATA_WIDTH-2:0], b} : {b, w[DATA_WIDTH-1:1]};
  endfunction

  logic sclk, mosi, cs_n;

`ifdef SPI_SLAVE_INPUT_SYNC_EN
  logic [1:0] sclk_sync, mosi_sync, cs_sync;

  // Two-flop synchronisers for the asynchronous SPI pins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync <= {2{IDLE_LVL}};
      mosi_sync <= 2'b00;
      cs_sync   <= 2'b11;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_sclk_i};
      mosi_sync <= {mosi_sync[0], spi_mosi_i};
      cs_sync   <= {cs_sync[0], spi_cs_i};
    end
  end

  assign sclk = sclk_sync[1];
  assign mosi = mosi_sync[1];
  assign cs_n = cs_sync[1];
`else
  assign sclk = spi_sclk_i;
  assign mosi = spi_mosi_i;
  assign cs_n = spi_cs_i;
`endif

  state_t                state, state_next;
  logic                  armed;         // CS has been seen high since reset
  logic                  sclk_prev;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] tx_buf, tx_sr, rx_sr, rx_data, load_word;
  logic                  tx_empty, miso_bit, rx_valid, underrun, underrun_pend, busy;
  logic                  lead_edge, trail_edge, sample_edge, shift_edge, word_end;

  assign lead_edge   = (sclk != sclk_prev) && (sclk_prev == IDLE_LVL);
  assign trail_edge  = (sclk != sclk_prev) && (sclk == IDLE_LVL);
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  // In mode CPHA=0 the trailing edge right after the last sample of a word must
  // not shift: LOAD has already presented bit 0 of the next word by then.
  assign shift_edge  = (CPHA != 0) ? lead_edge : (trail_edge && (bit_cnt != {CNT_W{1'b0}}));
  assign word_end    = (state == SHIFT) && sample_edge && (bit_cnt == CNT_W'(DATA_WIDTH - 1));
  assign load_word   = tx_empty ? {DATA_WIDTH{1'b0}} : tx_buf;

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; CS high always wins.
  always_comb begin
    state_next = state;
    if (cs_n) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (armed) state_next = LOAD; else state_next = IDLE;
        LOAD:    state_next = SHIFT;
        SHIFT:   if (word_end) state_next = LOAD; else state_next = SHIFT;
        default: state_next = IDLE;
      endcase
    end
  end

  // TX buffer, shifters, bit counter and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      armed         <= 1'b0;
      sclk_prev     <= IDLE_LVL;
      bit_cnt       <= {CNT_W{1'b0}};
      tx_buf        <= {DATA_WIDTH{1'b0}};
      tx_empty      <= 1'b1;
      tx_sr         <= {DATA_WIDTH{1'b0}};
      rx_sr         <= {DATA_WIDTH{1'b0}};
      rx_data       <= {DATA_WIDTH{1'b0}};
      rx_valid      <= 1'b0;
      miso_bit      <= 1'b0;
      underrun      <= 1'b0;
      underrun_pend <= 1'b0;
      busy          <= 1'b0;
    end else begin
      sclk_prev <= sclk;
      busy      <= ~cs_n;
      rx_valid  <= 1'b0;
      underrun  <= 1'b0;
      if (cs_n) armed <= 1'b1; else armed <= armed;

      // Buffer is drained by LOAD (only when full) and filled by a write (only
      // when empty), so both can never happen in the same cycle.
      if ((state == LOAD) && !tx_empty) begin
        tx_empty <= 1'b1;
      end else if (bus.tx_valid_i && tx_empty) begin
        tx_buf   <= bus.tx_data_bi;
        tx_empty <= 1'b0;
      end else begin
        tx_empty <= tx_empty;
      end

      if (cs_n || (state == IDLE)) begin
        bit_cnt       <= {CNT_W{1'b0}};
        tx_sr         <= {DATA_WIDTH{1'b0}};
        rx_sr         <= {DATA_WIDTH{1'b0}};
        miso_bit      <= 1'b0;
        underrun_pend <= 1'b0;
      end else if (state == LOAD) begin
        underrun_pend <= tx_empty;
        if (CPHA == 0) begin
          miso_bit <= tx_head(load_word);
          tx_sr    <= tx_next(load_word);
        end else begin
          miso_bit <= 1'b0;
          tx_sr    <= load_word;
        end
      end else begin
        // Underrun is reported once the word actually starts clocking, so a
        // LOAD that CS high cuts short does not count as a word.
        if (underrun_pend && (sample_edge || shift_edge)) begin
          underrun      <= 1'b1;
          underrun_pend <= 1'b0;
        end else begin
          underrun_pend <= underrun_pend;
        end
        if (sample_edge) begin
          rx_sr <= rx_insert(rx_sr, mosi);
          if (word_end) begin
            bit_cnt  <= {CNT_W{1'b0}};
            rx_data  <= rx_insert(rx_sr, mosi);
            rx_valid <= 1'b1;
          end else begin
            bit_cnt  <= bit_cnt + CNT_W'(1);
          end
        end else if (shift_edge) begin
          miso_bit <= tx_head(tx_sr);
          tx_sr    <= tx_next(tx_sr);
        end else begin
          bit_cnt <= bit_cnt;
        end
      end
    end
  end

  assign bus.tx_ready_o = tx_empty;
  assign bus.rx_data_bo = rx_data;
  assign bus.rx_valid_o = rx_valid;
  assign busy_o         = busy;
  assign underrun_o     = underrun;
  // Gated with CS so the line is released the moment CS rises.
  assign spi_miso_o     = miso_bit & ~cs_n;
endmodule

// File: doc/spi_slave_stream.md
SPI_SLAVE_STREAM -- requirements
Module: spi_slave_stream

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, bits per SPI word (legal 4..32).
REQ-002 The block SHALL have parameter CPOL, default 0, SCLK idle level.
REQ-003 The block SHALL have parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 The block SHALL have parameter MSB_FIRST, default 0: 0 = LSB first, 1 = MSB first, both directions.
REQ-005 The block SHALL have one clock and a synchronous active-high reset: clk_i  input  1  system clock; rst_i  input  1  reset.
REQ-006 The block SHALL have tx_data_bi  input  DATA_WIDTH  word to return to master; tx_valid_i  input  1  tx_data_bi valid; tx_ready_o  output  1  TX buffer empty.
REQ-007 The block SHALL have rx_data_bo  output  DATA_WIDTH  last complete word from master; rx_valid_o  output  1  one-cycle strobe, new rx_data_bo.
REQ-008 The block SHALL have busy_o  output  1  CS asserted; underrun_o  output  1  one-cycle strobe, word started with TX buffer empty.
REQ-009 The block SHALL have spi_miso_o  output  1; spi_mosi_i  input  1; spi_sclk_i  input  1; spi_cs_i  input  1  active-low chip select.

Function
REQ-010 The block SHALL hold a one-deep TX buffer: write on clk_i when tx_valid_i && tx_ready_o; tx_ready_o = buffer empty.
REQ-011 The block SHALL implement states IDLE (CS high), LOAD (word start), SHIFT (bits in flight); IDLE->LOAD on CS low, LOAD->SHIFT after one clk_i, SHIFT->LOAD after DATA_WIDTH samples, any->IDLE on CS high.
REQ-012 In LOAD the block SHALL move the TX buffer into the shifter and empty the buffer; if the buffer is empty it SHALL load all-zeros and pulse underrun_o.
REQ-013 The block SHALL detect SCLK edges by comparing spi_sclk_i with its registered previous value; leading edge = departure from CPOL level.
REQ-014 With CPHA=0 the first bit SHALL appear on spi_miso_o after LOAD, MOSI SHALL be sampled on leading edges and MISO advanced on trailing edges.
REQ-015 With CPHA=1 MISO SHALL be advanced (first bit presented) on leading edges and MOSI sampled on trailing edges.
REQ-016 The bit counter SHALL count samples 0..DATA_WIDTH-1 and wrap to 0 at word end.
REQ-017 On the DATA_WIDTH-th sample, rx_data_bo SHALL update and rx_valid_o pulse exactly one clk_i cycle later; rx_data_bo SHALL hold until the next complete word.
REQ-018 While CS stays low after a word, the block SHALL re-enter LOAD and continue with the next word without gap.
REQ-019 CS rising mid-word SHALL abort: partial RX discarded, no rx_valid_o, counter cleared, loaded TX word lost, TX buffer unaffected.
REQ-020 spi_miso_o SHALL be 0 whenever CS is high; busy_o SHALL equal inverted spi_cs_i as used internally.
REQ-021 clk_i SHALL be at least 4x SCLK frequency; slower clk_i is outside specification.
REQ-022 A TX buffer write in the same cycle as LOAD SHALL NOT be loaded into that word (tx_ready_o is 0 during that cycle's write arbitration if buffer full; if empty, LOAD underruns and the write fills the buffer).

Reset
REQ-023 With rst_i high at a clk_i edge the block SHALL enter IDLE, clear shifter, counter and TX buffer, and drive rx_data_bo=0, rx_valid_o=0, underrun_o=0, busy_o=0, spi_miso_o=0, tx_ready_o=1.
REQ-024 Reset mid-transfer SHALL take precedence; after release with CS still low the block SHALL wait for CS high before accepting a new word.

Configuration
REQ-025 With macro SPI_SLAVE_INPUT_SYNC_EN defined, spi_sclk_i, spi_mosi_i, spi_cs_i SHALL pass through two-flop synchronisers (reset to CPOL, 0, 1), adding 2 clk_i latency to all SPI-derived events; undefined, inputs SHALL be used directly and the integrator guarantees synchronism.

Verification
REQ-026 Mode 0, W=8, LSB first: tx 0xA5 preloaded, master sends 0x3C -> master reads 0xA5, rx_data_bo=0x3C, single rx_valid_o pulse.
REQ-027 CPOL=1 CPHA=1, W=16, MSB first: tx 0x1234, master sends 0xBEEF -> master reads 0x1234, rx_data_bo=0xBEEF.
REQ-028 Two-word burst, only 0x11 written -> master reads 0x11 then 0x00, one underrun_o pulse, two rx_valid_o pulses.
REQ-029 CS raised after 3 SCLK cycles -> no rx_valid_o, spi_miso_o=0, next full word 0x5A received correctly.
REQ-030 rst_i mid-word then CS high/low, word 0x81 -> all outputs at reset values, then 0x81 received with one rx_valid_o.
